irrigation_countdown_ctrl: RTL and testbench
============================================

// Module: irrigation_countdown_ctrl
// PURPOSE
//   Downstream consumer of the BCD down-counter digits: cascades four BCD digits into an
//   MM:SS countdown (00:00..59:59) with a seconds prescaler and a run/pause/done FSM.
//   Drives the irrigation valve while the countdown runs. Pulses done when 00:00 is reached.
//   Sits between the operator preset/keys and the valve driver.
// PARAMETERS
//   TICK_DIV  4  clock cycles per 1 s tick, >=2. Production value is set at top level.
//   PS_W      16  prescaler counter width; must satisfy 2**PS_W >= TICK_DIV.
// PORTS
//   clock         in   1   system clock; all state changes on posedge
//   reset         in   1   synchronous reset, active-low (0 at posedge clears block)
//   preset_bus    in   16  BCD preset {min_tens, min_units, sec_tens, sec_units}
//   load          in   1   load preset_bus (level sampled each edge)
//   start         in   1   start / resume countdown
//   pause         in   1   pause running countdown
//   abort         in   1   cancel, clear time, return to IDLE
//   time_bus      out  16  current BCD time, same digit order as preset_bus
//   state         out  2   IDLE=0, RUNNING=1, PAUSED=2, DONE=3
//   valve_on      out  1   1 only while state==RUNNING
//   done          out  1   1-cycle pulse on the edge time reaches 00:00
//   preset_error  out  1   1-cycle pulse when a load is rejected for an invalid digit
// BEHAVIOUR
//   - Reset (reset==0 at posedge): state=IDLE, time_bus=0, prescaler=0, valve_on=0, done=0,
//     preset_error=0. Reset takes effect mid-operation too.
//   - Command priority per edge: reset > abort > load > pause > start.
//   - All outputs are registered. valve_on is asserted on the same edge the state enters
//     RUNNING and deasserted on the same edge it leaves RUNNING.
//   - abort (any state): next edge state=IDLE, time_bus=0000, prescaler=0.
//   - load: accepted only in IDLE or DONE; ignored in RUNNING and PAUSED.
//       - Valid when min_tens<=5, sec_tens<=5, and both units digits <=9.
//       - Valid load: time_bus=preset_bus and state=IDLE next edge.
//       - Invalid load: time_bus and state unchanged; preset_error=1 for one cycle.
//   - start:
//       - IDLE with time_bus!=0: RUNNING, prescaler=0.
//       - PAUSED: RUNNING, prescaler resumes from its held value.
//       - IDLE with 0000, DONE, or RUNNING: ignored.
//   - pause: in RUNNING -> PAUSED with the prescaler held. Ignored in other states.
//   - Prescaler: counts only in RUNNING, 0..TICK_DIV-1. A tick occurs on the edge where
//     prescaler==TICK_DIV-1, and the prescaler wraps to 0 on that edge.
//     The first decrement happens TICK_DIV cycles after the start edge.
//   - Tick decrement, BCD with borrow:
//       - sec_units 0->9 borrows from sec_tens.
//       - sec_tens 0->5 borrows from min_units.
//       - min_units 0->9 borrows from min_tens.
//       - A digit never holds a non-BCD value.
//   - Tick leaving 0000: state=DONE, valve_on=0, done=1 for that one cycle;
//     time_bus holds 0000 in DONE.
//   - pause and tick on the same edge: the decrement is applied, then the state becomes
//     PAUSED. If that decrement reaches 0000, DONE takes precedence over PAUSED.
//   - abort/load/reset on a tick edge: the tick is discarded.
// TESTING (TICK_DIV=4)
//   1. Reset, load 0x0002, start -> valve_on=1 next edge; 0x0001 after 4 clocks; 0x0000
//      after 8 with done=1 for exactly 1 cycle, state=3, valve_on=0.
//   2. Load 0x1000, start -> after first tick time_bus=0x0959 (full borrow chain); load
//      0x0100 -> first tick 0x0059.
//   3. Load 0x0060 (sec_tens=6), then 0x6000, then 0x000A -> preset_error pulse each time;
//      time_bus and state unchanged.
//   4. Load 0x0005, start, pause after 2 clocks, hold 10 clocks -> time 0x0005, valve_on=0,
//      state=2. Then start -> 0x0004 exactly 2 clocks later.
//   5. Running at 0x0030: abort -> next edge IDLE, 0x0000, valve_on=0. Repeat with reset=0
//      -> identical.
//   6. Start at 0x0000 -> stays IDLE; load 0x0100 while RUNNING -> ignored. Pause and start
//      asserted together while RUNNING -> PAUSED.

Source files
------------

// File: rtl/irrigation_countdown_ctrl.sv
// MM:SS BCD countdown (00:00..59:59) with a seconds prescaler and an
// IDLE/RUNNING/PAUSED/DONE FSM that drives the irrigation valve.
module irrigation_countdown_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int PS_W     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] preset_bus,
  input  logic        load,
  input  logic        start,
  input  logic        pause,
  input  logic        abort,
  output logic [15:0] time_bus,
  output logic [1:0]  state,
  output logic        valve_on,
  output logic        done,
  output logic        preset_error
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] ps_q;
  logic [PS_W-1:0] ps_n;
  logic [15:0]     time_n;
  logic [15:0]     time_dec;
  logic [1:0]      state_n;
  logic            done_n;
  logic            err_n;
  logic            tick;
  logic            preset_ok;
  logic            load_window;

  // Digit order is {min_tens, min_units, sec_tens, sec_units}.
  function automatic logic bcd_time_valid(input logic [15:0] t);
    return (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) &&
           (t[7:4]   <= 4'd5) && (t[3:0]  <= 4'd9);
  endfunction

  // One-second decrement with a borrow chain; 0000 is never fed in because
  // the FSM leaves RUNNING on the tick that reaches it.
  function automatic logic [15:0] bcd_time_dec(input logic [15:0] t);
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          if (mt != 4'd0) begin
            mt = mt - 4'd1;
          end
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  assign tick        = (state == ST_RUNNING) && (ps_q == PS_LAST);
  assign time_dec    = bcd_time_dec(time_bus);
  assign preset_ok   = bcd_time_valid(preset_bus);
  assign load_window = (state == ST_IDLE) || (state == ST_DONE);

  // Commands resolve abort > load > pause > start; a load outside IDLE/DONE
  // has no effect at all, so the lower-priority commands still apply.
  always_comb begin
    state_n = state;
    time_n  = time_bus;
    ps_n    = ps_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (abort) begin
      state_n = ST_IDLE;
      time_n  = 16'h0000;
      ps_n    = '0;
    end else if (load && load_window) begin
      if (preset_ok) begin
        time_n  = preset_bus;
        state_n = ST_IDLE;
      end else begin
        err_n = 1'b1;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (time_bus != 16'h0000)) begin
            state_n = ST_RUNNING;
            ps_n    = '0;
          end
        end
        ST_RUNNING: begin
          ps_n = tick ? '0 : (ps_q + PS_ONE);
          if (tick) begin
            time_n = time_dec;
          end
          // Reaching 00:00 wins over a simultaneous pause.
          if (tick && (time_dec == 16'h0000)) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end else if (pause) begin
            state_n = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (start) begin
            state_n = ST_RUNNING;
          end
        end
        default: begin
          state_n = state;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_IDLE;
      time_bus     <= 16'h0000;
      ps_q         <= '0;
      valve_on     <= 1'b0;
      done         <= 1'b0;
      preset_error <= 1'b0;
    end else begin
      state        <= state_n;
      time_bus     <= time_n;
      ps_q         <= ps_n;
      valve_on     <= (state_n == ST_RUNNING);
      done         <= done_n;
      preset_error <= err_n;
    end
  end

endmodule

// File: tb/tb_irrigation_countdown_ctrl.sv
// Directed bench for irrigation_countdown_ctrl with TICK_DIV=4: a vector
// table for the basic flow plus hand-written multi-cycle sequences.
module tb_irrigation_countdown_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] preset_bus = 16'h0000;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] time_bus;
  logic [1:0]  state;
  logic        valve_on;
  logic        done;
  logic        preset_error;

  int n_checks = 0;
  int n_fail   = 0;

  irrigation_countdown_ctrl #(.TICK_DIV(4), .PS_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .preset_bus   (preset_bus),
    .load         (load),
    .start        (start),
    .pause        (pause),
    .abort        (abort),
    .time_bus     (time_bus),
    .state        (state),
    .valve_on     (valve_on),
    .done         (done),
    .preset_error (preset_error)
  );

  // Clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic        ld;
    logic        st;
    logic        ps;
    logic        ab;
    logic [15:0] pre;
    logic [15:0] e_time;
    logic [1:0]  e_state;
    logic        e_valve;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, input logic ld, input logic st,
                              input logic ps, input logic ab, input logic [15:0] pre,
                              input logic [15:0] e_time, input logic [1:0] e_state,
                              input logic e_valve, input logic e_done, input logic e_err);
    vec_t v;
    v.rst_n = rst_n; v.ld = ld; v.st = st; v.ps = ps; v.ab = ab; v.pre = pre;
    v.e_time = e_time; v.e_state = e_state; v.e_valve = e_valve;
    v.e_done = e_done; v.e_err = e_err;
    return v;
  endfunction

  // Driver: apply inputs for one posedge, then sample 1 time unit later.
  task automatic step(input logic rst_n, input logic ld, input logic st,
                      input logic ps, input logic ab, input logic [15:0] pre);
    reset = rst_n; load = ld; start = st; pause = ps; abort = ab; preset_bus = pre;
    @(posedge clock);
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  // Scoreboard compare
  task automatic chk(input string nm, input logic [15:0] e_time, input logic [1:0] e_state,
                     input logic e_valve, input logic e_done, input logic e_err);
    n_checks++;
    if ({time_bus, state, valve_on, done, preset_error} !==
        {e_time, e_state, e_valve, e_done, e_err}) begin
      n_fail++;
      $display("FAIL %s: got time=%h state=%0d valve=%b done=%b err=%b, expected time=%h state=%0d valve=%b done=%b err=%b",
               nm, time_bus, state, valve_on, done, preset_error,
               e_time, e_state, e_valve, e_done, e_err);
    end
  endtask

  initial begin
    // rst, ld, st, ps, ab, preset  ->  time, state, valve, done, err
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0002, 16'h0002, 2'd0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 16'h0002, 2'd1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0002, 2'd1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0002, 2'd1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0002, 2'd1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0001, 2'd1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0001, 2'd1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0001, 2'd1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0001, 2'd1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'd3, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'd3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 16'h0000, 2'd3, 0, 0, 0));
    // Invalid presets rejected in DONE and in IDLE
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0060, 16'h0000, 2'd3, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h6000, 16'h0000, 2'd3, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h000A, 16'h0000, 2'd3, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'd3, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0A00, 16'h0000, 2'd3, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h5959, 16'h5959, 2'd0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0060, 16'h5959, 2'd0, 0, 0, 1));
    // Abort clears; start at 0000 ignored
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h0000, 16'h0000, 2'd0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].ld, vecs[i].st, vecs[i].ps, vecs[i].ab, vecs[i].pre);
      chk($sformatf("vec[%0d]", i), vecs[i].e_time, vecs[i].e_state,
          vecs[i].e_valve, vecs[i].e_done, vecs[i].e_err);
    end

    // Full borrow chain 10:00 -> 09:59, then 01:00 -> 00:59
    step(1, 1, 0, 0, 0, 16'h1000);
    step(1, 0, 1, 0, 0, 16'h0000);
    nop(3);
    chk("borrow_pre", 16'h1000, 2'd1, 1, 0, 0);
    nop(1);
    chk("borrow_1000", 16'h0959, 2'd1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 16'h0000);
    chk("abort_run", 16'h0000, 2'd0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 16'h0100);
    step(1, 0, 1, 0, 0, 16'h0000);
    nop(4);
    chk("borrow_0100", 16'h0059, 2'd1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 16'h0000);

    // Pause holds time and prescaler; resume ticks 2 clocks later
    step(1, 1, 0, 0, 0, 16'h0005);
    step(1, 0, 1, 0, 0, 16'h0000);
    nop(1);
    step(1, 0, 0, 1, 0, 16'h0000);
    chk("pause_enter", 16'h0005, 2'd2, 0, 0, 0);
    nop(10);
    chk("pause_hold", 16'h0005, 2'd2, 0, 0, 0);
    step(1, 0, 1, 0, 0, 16'h0000);
    chk("resume", 16'h0005, 2'd1, 1, 0, 0);
    nop(1);
    chk("resume_wait", 16'h0005, 2'd1, 1, 0, 0);
    nop(1);
    chk("resume_tick", 16'h0004, 2'd1, 1, 0, 0);
    // Pause on a tick edge: decrement applied, then PAUSED
    nop(3);
    step(1, 0, 0, 1, 0, 16'h0000);
    chk("pause_on_tick", 16'h0003, 2'd2, 0, 0, 0);
    step(1, 0, 0, 0, 1, 16'h0000);

    // Pause on the tick reaching 0000: DONE wins
    step(1, 1, 0, 0, 0, 16'h0001);
    step(1, 0, 1, 0, 0, 16'h0000);
    nop(3);
    step(1, 0, 0, 1, 0, 16'h0000);
    chk("pause_at_zero", 16'h0000, 2'd3, 0, 1, 0);

    // Abort and reset mid-run at 00:30
    step(1, 1, 0, 0, 0, 16'h0031);
    step(1, 0, 1, 0, 0, 16'h0000);
    nop(4);
    chk("run_0030", 16'h0030, 2'd1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 16'h0000);
    chk("abort_0030", 16'h0000, 2'd0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 16'h0031);
    step(1, 0, 1, 0, 0, 16'h0000);
    nop(4);
    step(0, 0, 0, 0, 0, 16'h0000);
    chk("reset_0030", 16'h0000, 2'd0, 0, 0, 0);

    // Abort on a tick edge discards the tick
    step(1, 1, 0, 0, 0, 16'h0002);
    step(1, 0, 1, 0, 0, 16'h0000);
    nop(3);
    step(1, 0, 0, 0, 1, 16'h0000);
    chk("abort_on_tick", 16'h0000, 2'd0, 0, 0, 0);

    // Loads ignored while RUNNING/PAUSED; pause beats start
    step(1, 1, 0, 0, 0, 16'h0100);
    step(1, 0, 1, 0, 0, 16'h0000);
    step(1, 1, 0, 0, 0, 16'h0200);
    chk("load_in_run", 16'h0100, 2'd1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 16'h0000);
    chk("pause_and_start", 16'h0100, 2'd2, 0, 0, 0);
    step(1, 1, 0, 0, 0, 16'h0060);
    chk("load_in_pause", 16'h0100, 2'd2, 0, 0, 0);
    step(1, 0, 1, 0, 0, 16'h0000);
    nop(1);
    chk("resume_2", 16'h0100, 2'd1, 1, 0, 0);
    nop(1);
    chk("resume_2_tick", 16'h0059, 2'd1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
